// File: rtl/segment_assembler.sv
// Assembles an X,Y,Z byte stream into consecutive toolpath points and emits line segments.
// Latency: segment strobe one cycle after the Z byte of the end point is accepted.
// Backpressure: byte_rdy is low only during the single EMIT cycle; bytes transfer on byte_val & byte_rdy.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   path_start          one-cycle pulse: clears path state and discards any partial point
//   byte_in/byte_val    coordinate byte stream (X, Y, Z per point), byte_rdy is the accept qualifier
//   seg_val             one-cycle segment strobe
//   x1,y1,z1 / x2,y2,z2 segment start / end coordinates, held until the next emitted segment
//   seg_count           segments emitted in the current path (saturates at MAX_SEGS)
//   overflow            sticky: a segment was dropped because MAX_SEGS had been reached
//
// Build option: define SEGASM_SKIP_ZERO_LEN_EN to silently drop zero-length segments.
module segment_assembler #(
    parameter int MAX_SEGS = 61
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       path_start,
    input  logic [7:0] byte_in,
    input  logic       byte_val,
    output logic       byte_rdy,
    output logic       seg_val,
    output logic [7:0] x1,
    output logic [7:0] y1,
    output logic [7:0] z1,
    output logic [7:0] x2,
    output logic [7:0] y2,
    output logic [7:0] z2,
    output logic [7:0] seg_count,
    output logic       overflow
);

    // seg_count is 8 bits, so a limit above 255 behaves as 255.
    localparam int         SEG_CAP = (MAX_SEGS > 255) ? 255 : MAX_SEGS;
    localparam logic [7:0] MAX_CNT = SEG_CAP[7:0];

    typedef enum logic [1:0] {
        GET_X = 2'd0,
        GET_Y = 2'd1,
        GET_Z = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0] cur_x, cur_y, cur_z;
    logic [7:0] prev_x, prev_y, prev_z;
    logic       have_prev;

    logic byte_acc;
    logic z_acc;
    logic zero_len;
    logic at_max;
    logic emit_go;

    assign byte_acc = byte_val && byte_rdy;
    // A Z byte arriving with path_start is dropped, so it never completes a point.
    assign z_acc    = (state == GET_Z) && byte_acc && !path_start;
    assign at_max   = (seg_count >= MAX_CNT);

`ifdef SEGASM_SKIP_ZERO_LEN_EN
    // Z is compared against the incoming byte because cur_z is not yet loaded.
    assign zero_len = have_prev && (prev_x == cur_x) && (prev_y == cur_y) && (prev_z == byte_in);
`else
    assign zero_len = 1'b0;
`endif

    assign emit_go = z_acc && have_prev && !zero_len && !at_max;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GET_X;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and flow-control outputs
    always_comb begin
        state_nxt = state;
        byte_rdy  = 1'b1;
        seg_val   = 1'b0;
        case (state)
            GET_X: if (byte_acc) state_nxt = GET_Y;
            GET_Y: if (byte_acc) state_nxt = GET_Z;
            GET_Z: if (byte_acc) state_nxt = emit_go ? EMIT : GET_X;
            EMIT: begin
                byte_rdy  = 1'b0;
                // Strobe is decoded from state so an asynchronous reset kills it at once.
                seg_val   = 1'b1;
                state_nxt = GET_X;
            end
            default: state_nxt = GET_X;
        endcase
        // path_start wins over any byte in the same cycle; an EMIT strobe still goes out.
        if (path_start) begin
            state_nxt = GET_X;
        end
    end

    // Point, segment and path bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
            cur_z     <= 8'd0;
            prev_x    <= 8'd0;
            prev_y    <= 8'd0;
            prev_z    <= 8'd0;
            have_prev <= 1'b0;
            x1        <= 8'd0;
            y1        <= 8'd0;
            z1        <= 8'd0;
            x2        <= 8'd0;
            y2        <= 8'd0;
            z2        <= 8'd0;
            seg_count <= 8'd0;
            overflow  <= 1'b0;
        end else if (path_start) begin
            have_prev <= 1'b0;
            seg_count <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                GET_X: if (byte_acc) cur_x <= byte_in;
                GET_Y: if (byte_acc) cur_y <= byte_in;
                GET_Z: begin
                    if (byte_acc) begin
                        cur_z <= byte_in;
                        if (!have_prev) begin
                            // First point of the path only seeds the previous point.
                            prev_x    <= cur_x;
                            prev_y    <= cur_y;
                            prev_z    <= byte_in;
                            have_prev <= 1'b1;
                        end else if (zero_len) begin
                            // Dropped silently; previous point already equals this one.
                        end else if (at_max) begin
                            // Suppressed segment: outputs hold, path still advances.
                            overflow <= 1'b1;
                            prev_x   <= cur_x;
                            prev_y   <= cur_y;
                            prev_z   <= byte_in;
                        end else begin
                            // Load the segment now so it is valid during the EMIT cycle.
                            x1 <= prev_x;
                            y1 <= prev_y;
                            z1 <= prev_z;
                            x2 <= cur_x;
                            y2 <= cur_y;
                            z2 <= byte_in;
                        end
                    end
                end
                EMIT: begin
                    prev_x <= cur_x;
                    prev_y <= cur_y;
                    prev_z <= cur_z;
                    if (seg_count != 8'hFF) begin
                        seg_count <= seg_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_assembler.sv
module tb_segment_assembler;

    logic       clk;
    logic       reset;
    logic       path_start;
    logic [7:0] byte_in;
    logic       byte_val;
    logic       byte_rdy;
    logic       seg_val;
    logic [7:0] x1, y1, z1, x2, y2, z2;
    logic [7:0] seg_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    int  pulse_cnt   = 0;
    int  consec_hits = 0;
    logic seg_val_d  = 1'b0;

    segment_assembler #(.MAX_SEGS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .path_start (path_start),
        .byte_in    (byte_in),
        .byte_val   (byte_val),
        .byte_rdy   (byte_rdy),
        .seg_val    (seg_val),
        .x1         (x1),
        .y1         (y1),
        .z1         (z1),
        .x2         (x2),
        .y2         (y2),
        .z2         (z2),
        .seg_count  (seg_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes and catch back-to-back seg_val, sampled mid-cycle.
    always @(negedge clk) begin
        if (seg_val) pulse_cnt++;
        if (seg_val && seg_val_d) consec_hits++;
        seg_val_d = seg_val;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Waits (bounded) for byte_rdy, transfers one byte, returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!byte_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rdy_timeout", 32'(byte_rdy), 32'd1);
        byte_in  = b;
        byte_val = 1'b1;
        @(posedge clk);
        #1;
        byte_val = 1'b0;
    endtask

    task automatic send_point(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        send_byte(x);
        send_byte(y);
        send_byte(z);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        path_start = 1'b1;
        @(posedge clk);
        #1;
        path_start = 1'b0;
    endtask

    task automatic check_seg(input string tag,
                             input logic [7:0] ex1, input logic [7:0] ey1, input logic [7:0] ez1,
                             input logic [7:0] ex2, input logic [7:0] ey2, input logic [7:0] ez2);
        check({tag, "_val"}, 32'(seg_val), 32'd1);
        check({tag, "_x1"}, 32'(x1), 32'(ex1));
        check({tag, "_y1"}, 32'(y1), 32'(ey1));
        check({tag, "_z1"}, 32'(z1), 32'(ez1));
        check({tag, "_x2"}, 32'(x2), 32'(ex2));
        check({tag, "_y2"}, 32'(y2), 32'(ey2));
        check({tag, "_z2"}, 32'(z2), 32'(ez2));
    endtask

    initial begin
        int exp_pulses;
        reset      = 1'b1;
        path_start = 1'b0;
        byte_in    = 8'd0;
        byte_val   = 1'b0;
        exp_pulses = 0;

        // Reset state
        #12;
        check("rst_seg_val", 32'(seg_val), 32'd0);
        check("rst_count", 32'(seg_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_x1", 32'(x1), 32'd0);
        check("rst_z2", 32'(z2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_rdy", 32'(byte_rdy), 32'd1);

        // Two points -> first segment, strobe one cycle after Z byte
        send_point(8'd10, 8'd10, 8'd5);
        check("p1_noemit", 32'(seg_val), 32'd0);
        send_point(8'd20, 8'd20, 8'd5);
        check_seg("s1", 8'd10, 8'd10, 8'd5, 8'd20, 8'd20, 8'd5);
        check("s1_rdy_low", 32'(byte_rdy), 32'd0);
        exp_pulses++;
        @(posedge clk);
        #1;
        check("s1_val_off", 32'(seg_val), 32'd0);
        check("s1_count", 32'(seg_count), 32'd1);
        check("s1_rdy_back", 32'(byte_rdy), 32'd1);

        // Third point chains from the previous end point
        send_point(8'd30, 8'd5, 8'd5);
        check_seg("s2", 8'd20, 8'd20, 8'd5, 8'd30, 8'd5, 8'd5);
        check("s2_rdy_low", 32'(byte_rdy), 32'd0);
        exp_pulses++;
        @(posedge clk);
        #1;
        check("s2_count", 32'(seg_count), 32'd2);

        // At MAX_SEGS=2 the fourth point is suppressed, outputs hold
        send_point(8'd40, 8'd40, 8'd40);
        check("ovf_noemit", 32'(seg_val), 32'd0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(seg_count), 32'd2);
        check("ovf_hold_x2", 32'(x2), 32'd30);
        check("ovf_rdy", 32'(byte_rdy), 32'd1);

        // path_start clears the path; next point only seeds
        pulse_start();
        check("ps_ovf", 32'(overflow), 32'd0);
        check("ps_count", 32'(seg_count), 32'd0);
        send_point(8'd1, 8'd1, 8'd1);
        check("ps_noemit", 32'(seg_val), 32'd0);

        // path_start in the same cycle as the Z byte drops it
        pulse_start();
        send_byte(8'd1);
        send_byte(8'd2);
        @(negedge clk);
        byte_in    = 8'd3;
        byte_val   = 1'b1;
        path_start = 1'b1;
        @(posedge clk);
        #1;
        byte_val   = 1'b0;
        path_start = 1'b0;
        check("drop_noemit", 32'(seg_val), 32'd0);
        check("drop_rdy", 32'(byte_rdy), 32'd1);
        send_point(8'd4, 8'd5, 8'd6);
        check("drop_seed", 32'(seg_val), 32'd0);
        send_point(8'd7, 8'd8, 8'd9);
        check_seg("drop_seg", 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
        exp_pulses++;
        @(posedge clk);
        #1;
        check("drop_count", 32'(seg_count), 32'd1);

        // path_start during EMIT: strobe still seen, then cleared
        send_point(8'd10, 8'd11, 8'd12);
        path_start = 1'b1;
        #1;
        check_seg("pse", 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12);
        exp_pulses++;
        @(posedge clk);
        #1;
        path_start = 1'b0;
        check("pse_count", 32'(seg_count), 32'd0);
        check("pse_val_off", 32'(seg_val), 32'd0);

        // Zero-length segment
        send_point(8'd7, 8'd7, 8'd7);
        send_point(8'd7, 8'd7, 8'd7);
`ifdef SEGASM_SKIP_ZERO_LEN_EN
        check("zl_noemit", 32'(seg_val), 32'd0);
        @(posedge clk);
        #1;
        check("zl_count", 32'(seg_count), 32'd0);
        check("zl_ovf", 32'(overflow), 32'd0);
`else
        check_seg("zl", 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
        exp_pulses++;
        @(posedge clk);
        #1;
        check("zl_count", 32'(seg_count), 32'd1);
`endif

        // Asynchronous reset during EMIT
        pulse_start();
        send_point(8'd1, 8'd2, 8'd3);
        send_point(8'd4, 8'd5, 8'd6);
        check("ar_pre_val", 32'(seg_val), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("ar_val", 32'(seg_val), 32'd0);
        check("ar_x1", 32'(x1), 32'd0);
        check("ar_x2", 32'(x2), 32'd0);
        check("ar_z2", 32'(z2), 32'd0);
        check("ar_count", 32'(seg_count), 32'd0);
        check("ar_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_rdy", 32'(byte_rdy), 32'd1);
        send_point(8'd5, 8'd5, 8'd5);
        check("ar_seed", 32'(seg_val), 32'd0);

        @(negedge clk);
        @(negedge clk);
        check("pulse_total", 32'(pulse_cnt), 32'(exp_pulses));
        check("no_consec", 32'(consec_hits), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_assembler.md
SEGMENT_ASSEMBLER -- requirements
Module: segment_assembler

Interface
REQ-001 Parameter MAX_SEGS, default 61: maximum segments emitted per path, matching the collision-detect table depth.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 path_start  input  1  one-cycle pulse; starts a new toolpath.
REQ-005 byte_in  input  8  coordinate byte stream, ordered X, Y, Z per point.
REQ-006 byte_val  input  1  byte_in valid.
REQ-007 byte_rdy  output  1  block can accept a byte; a byte transfers when byte_val and byte_rdy are both high.
REQ-008 seg_val  output  1  one-cycle segment strobe; drives the collision detector's in_val.
REQ-009 x1, y1, z1, x2, y2, z2  output  8 each  segment start and end coordinates.
REQ-010 seg_count  output  8  number of segments emitted in the current path.
REQ-011 overflow  output  1  sticky flag: a segment was dropped because MAX_SEGS was reached.

Function
REQ-012 The FSM SHALL have states GET_X, GET_Y, GET_Z and EMIT; reset enters GET_X.
REQ-013 In GET_X, GET_Y and GET_Z, byte_rdy SHALL be 1; in EMIT, byte_rdy SHALL be 0.
REQ-014 Each accepted byte SHALL be latched into the current-point register for its axis and advance the state: GET_X -> GET_Y -> GET_Z.
REQ-015 When have_prev=0 and a Z byte is accepted, the block SHALL copy the current point to the previous point, set have_prev=1 and return to GET_X without emitting.
REQ-016 When have_prev=1 and a Z byte is accepted, the block SHALL enter EMIT on the next edge.
REQ-017 In EMIT, seg_val SHALL be 1 for exactly one cycle, with x1/y1/z1 = previous point and x2/y2/z2 = current point.
REQ-018 On leaving EMIT, the block SHALL copy the current point to the previous point, increment seg_count and return to GET_X.
REQ-019 Latency SHALL be exactly 1 cycle: Z byte accepted at edge N, seg_val high during cycle N+1.
REQ-020 x1..z2 SHALL hold their last emitted values until the next emit.
REQ-021 seg_val SHALL never be high in two consecutive cycles.
REQ-022 When seg_count equals MAX_SEGS, a segment that would be emitted SHALL be suppressed (seg_val stays 0) and overflow SHALL be set.
REQ-023 A suppressed segment SHALL still update the previous point; seg_count SHALL stay at MAX_SEGS.
REQ-024 On a path_start pulse, the block SHALL clear have_prev, seg_count and overflow, discard any partial point and go to GET_X.
REQ-025 path_start SHALL take priority over a byte accepted in the same cycle; that byte SHALL be dropped.
REQ-026 If path_start arrives during EMIT, the pending seg_val for that cycle SHALL still be output, then path_start clearing SHALL apply.
REQ-027 Coordinates SHALL be unsigned 8-bit values, passed through with no arithmetic applied.
REQ-028 seg_count SHALL be 8 bits wide and SHALL never wrap.

Reset
REQ-029 While reset is high, all state SHALL clear immediately without waiting for a clock edge.
REQ-030 Cleared outputs: seg_val=0, x1..z2=0, seg_count=0, overflow=0, have_prev=0, state=GET_X.
REQ-031 byte_rdy SHALL be 1 immediately after reset is released.
REQ-032 Reset asserted mid-point or mid-EMIT SHALL abort the point or segment with no seg_val pulse.

Configuration
REQ-033 Macro SEGASM_SKIP_ZERO_LEN_EN SHALL control zero-length segment handling.
REQ-034 When defined: a segment with x1=x2, y1=y2 and z1=z2 SHALL be dropped silently, with no seg_val, no seg_count increment and no overflow effect; the previous point is unchanged.
REQ-035 When undefined: zero-length segments SHALL be emitted like any other segment.

Verification
REQ-036 After reset, send points (10,10,5), (20,20,5) -> one seg_val with segment (10,10,5)-(20,20,5); seg_count=1; seg_val high 1 cycle after the Z byte.
REQ-037 Send a third point (30,5,5) -> seg_val with segment (20,20,5)-(30,5,5); seg_count=2; byte_rdy=0 only during the EMIT cycle.
REQ-038 With MAX_SEGS=2, send 4 points -> 2 seg_val pulses, overflow=1, seg_count=2; then pulse path_start -> overflow=0, seg_count=0, and the next point emits nothing.
REQ-039 Send X=1, Y=2, then path_start in the same cycle as byte 3 -> byte 3 dropped, no segment emitted, state GET_X.
REQ-040 Repeat point (7,7,7) twice -> one seg_val with segment (7,7,7)-(7,7,7) with the macro undefined; no seg_val and seg_count=0 with the macro defined.
REQ-041 Assert reset asynchronously in the EMIT cycle -> seg_val drops to 0 immediately, all outputs 0, byte_rdy=1 after release.
